func0_t0: RTL and testbench
===========================

FUNC0_T0 -- requirements
Module: func0_t0

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  rising-edge clock; all state changes on the rising edge.
REQ-003 Port rst  input  1  synchronous active-high reset; sampled on the clk rising edge.
REQ-004 Port z__value  input  8 signed  neuron pre-activation, Q4.4 two's complement (16 = 1.0).
REQ-005 Port a  output  8 signed  activation value, Q4.4 (range 0..16 = 0.0..1.0).

Function
REQ-006 The block SHALL compute a piecewise-linear sigmoid; identical instances serve as every neuron's activation.
REQ-007 Magnitude: m = |z__value| as 9-bit unsigned; z__value = -128 gives m = 128, with no overflow.
REQ-008 Internal value Y (Q.8, unsigned 9 bits) by segment:
- m < 16: Y = 4*m + 128.
- 16 <= m < 38: Y = 2*m + 160.
- 38 <= m < 80: Y = floor(m/2) + 216.
- m >= 80: Y = 256.
REQ-009 Rounding: P = (Y + 8) >> 4 (round half up), giving 0..16.
REQ-010 Sign: a = P when z__value >= 0; a = 16 - P when z__value < 0.
REQ-011 Output is always within 0..16; bits [7:5] of a are always 0.
REQ-012 Segment boundaries are inclusive on the lower bound exactly as in REQ-008.
REQ-013 No handshake: a new z__value is accepted every cycle; there is no stall or back-pressure.

Reset
REQ-014 With the output register compiled in (REQ-016), rst high at a rising edge SHALL load a = 0 on that edge.
REQ-015 When rst deasserts, the first rising edge with rst low SHALL register f(z__value); a reset mid-stream discards the in-flight value.

Configuration
REQ-016 Macro FUNC0_T0_REG_OUT_EN:
- Defined: a is registered, with 1-cycle latency from z__value sampled at a rising edge, and reset behaves per REQ-014.
- Undefined: a is purely combinational from z__value, with zero latency; clk and rst are unused but the ports remain.

Verification
REQ-017 z__value = 0 -> a = 8; z__value = 16 (+1.0) -> a = 12; z__value = -16 -> a = 4.
REQ-018 Boundary: z__value = 15 -> 12; z__value = 37 -> 15; z__value = 38 -> 15; z__value = 79 -> 16; z__value = 80 -> 16.
REQ-019 Extremes: z__value = 127 -> 16; z__value = -128 -> 0; z__value = -80 -> 0.
REQ-020 Symmetry: for every z in -127..127, a(z) + a(-z) = 16, checked by an exhaustive sweep against a reference model.
REQ-021 With FUNC0_T0_REG_OUT_EN: apply z__value = 16 at edge n -> a = 12 after edge n; assert rst at edge n+1 -> a = 0; release rst -> a follows one edge later.
REQ-022 Without FUNC0_T0_REG_OUT_EN: change z__value with no clock edge -> a updates within the same delta time.

Source files
------------

// File: rtl/func0_t0_if.sv
// Activation port bundle: signed Q4.4 pre-activation in, Q4.4 activation out.
interface func0_t0_if;
  logic signed [7:0] z__value;
  logic signed [7:0] a;

  modport master (output z__value, input a);
  modport slave  (input z__value, output a);
endinterface

// File: rtl/func0_t0.sv
// Piecewise-linear sigmoid on Q4.4 inputs, result in 0..16 (0.0..1.0).
// Define FUNC0_T0_REG_OUT_EN to register the output (1-cycle latency, sync reset to 0).
module func0_t0 (
  input  logic       clk,
  input  logic       rst,
  func0_t0_if.slave  bus
);

  logic [8:0]        m;
  logic [8:0]        y;
  logic [4:0]        p;
  logic [3:0]        rnd_unused;
  logic signed [7:0] a_c;

  // Nine-bit magnitude so that -128 maps to 128 without wrapping.
  always_comb begin
    m = bus.z__value[7] ? (9'd0 - {1'b1, bus.z__value}) : {1'b0, bus.z__value};
  end

  always_comb begin
    y = 9'd256;
    if (m < 9'd16)
      y = {3'b000, m[3:0], 2'b00} + 9'd128;
    else if (m < 9'd38)
      y = {2'b00, m[5:0], 1'b0} + 9'd160;
    else if (m < 9'd80)
      y = {1'b0, m[8:1]} + 9'd216;
  end

  // y tops out at 256, so y + 8 still fits in nine bits.
  assign {p, rnd_unused} = y + 9'd8;

  always_comb begin
    a_c = {3'b000, p};
    if (bus.z__value[7])
      a_c = {3'b000, 5'd16 - p};
  end

`ifdef FUNC0_T0_REG_OUT_EN
  logic signed [7:0] a_q;

  always_ff @(posedge clk) begin
    if (rst)
      a_q <= '0;
    else
      a_q <= a_c;
  end

  assign bus.a = a_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, rst};
  assign bus.a     = a_c;
`endif

endmodule

// File: tb/tb_func0_t0.sv
// Bench for func0_t0: directed table, reset/latency sequences, exhaustive symmetry sweep, random vectors.
module tb_func0_t0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  func0_t0_if bus ();

  func0_t0 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    z;
    int    a_exp;
    string name;
  } vec_t;

  vec_t vecs[11];

  // Sigmoid approximation evaluated straight from the segment rules in integer arithmetic.
  function automatic int ref_act(input int z);
    int mag, yv, pv;
    mag = (z < 0) ? -z : z;
    if (mag < 16)      yv = 4 * mag + 128;
    else if (mag < 38) yv = 2 * mag + 160;
    else if (mag < 80) yv = mag / 2 + 216;
    else               yv = 256;
    pv = (yv + 8) / 16;
    return (z >= 0) ? pv : 16 - pv;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Applies z and returns the activation once it is visible at the output.
  task automatic apply(input int z, output int act);
`ifdef FUNC0_T0_REG_OUT_EN
    @(negedge clk);
    bus.z__value = 8'(z);
    @(posedge clk);
    #1;
`else
    @(negedge clk);
    bus.z__value = 8'(z);
    #1;
`endif
    act = int'($signed(bus.a));
  endtask

  initial begin
    int act, act_neg, z;

    vecs[0]  = '{0,    8,  "zero"};
    vecs[1]  = '{16,   12, "plus_one"};
    vecs[2]  = '{-16,  4,  "minus_one"};
    vecs[3]  = '{15,   12, "bnd_15"};
    vecs[4]  = '{37,   15, "bnd_37"};
    vecs[5]  = '{38,   15, "bnd_38"};
    vecs[6]  = '{79,   16, "bnd_79"};
    vecs[7]  = '{80,   16, "bnd_80"};
    vecs[8]  = '{127,  16, "max_pos"};
    vecs[9]  = '{-128, 0,  "max_neg"};
    vecs[10] = '{-80,  0,  "neg_80"};

    bus.z__value = 8'sd37;
    rst = 1'b1;
    @(posedge clk);
    #1;
`ifdef FUNC0_T0_REG_OUT_EN
    check("reset_value", int'($signed(bus.a)), 0);
    @(posedge clk);
    #1;
    check("reset_hold", int'($signed(bus.a)), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", int'($signed(bus.a)), 15);
`else
    check("comb_during_rst", int'($signed(bus.a)), 15);
    @(negedge clk);
    rst = 1'b0;
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].z, act);
      check(vecs[i].name, act, vecs[i].a_exp);
    end

`ifdef FUNC0_T0_REG_OUT_EN
    // Output follows one edge later, reset mid-stream drops the in-flight value.
    @(negedge clk);
    bus.z__value = 8'sd16;
    @(posedge clk);
    #1;
    check("seq_lat_z16", int'($signed(bus.a)), 12);
    @(negedge clk);
    bus.z__value = -8'sd16;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("seq_mid_reset", int'($signed(bus.a)), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("seq_hold_before_edge", int'($signed(bus.a)), 0);
    @(posedge clk);
    #1;
    check("seq_release", int'($signed(bus.a)), 4);
    @(negedge clk);
    bus.z__value = 8'sd80;
    #1;
    check("seq_no_edge_no_change", int'($signed(bus.a)), 4);
    @(posedge clk);
    #1;
    check("seq_next_edge", int'($signed(bus.a)), 16);
`else
    // Zero latency: output tracks input between clock edges.
    @(negedge clk);
    bus.z__value = 8'sd16;
    #1;
    check("comb_z16", int'($signed(bus.a)), 12);
    bus.z__value = -8'sd16;
    #1;
    check("comb_zm16", int'($signed(bus.a)), 4);
    rst = 1'b1;
    bus.z__value = 8'sd0;
    #1;
    check("comb_ignores_rst", int'($signed(bus.a)), 8);
    rst = 1'b0;
`endif

    for (int zz = -127; zz <= 127; zz++) begin
      apply(zz, act);
      check("sweep_model", act, ref_act(zz));
      apply(-zz, act_neg);
      check("sweep_symmetry", act + act_neg, 16);
    end

    for (int k = 0; k < 300; k++) begin
      z = int'($urandom_range(255, 0)) - 128;
      apply(z, act);
      check("random_model", act, ref_act(z));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
